// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding,
// data width and the even-parity function.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_xmtr_state_t;

   localparam int UART_DATA_BITS = 8;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_xmtr_fifo.sv
// Byte FIFO feeding the UART transmitter. Pointers carry one extra wrap bit so
// full and empty are distinguishable without an occupancy counter.
module uart_xmtr_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] din_i,
   output logic [7:0] dout_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_xmtr_fifo: DEPTH must be a power of 2 and >= 2");
   end

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/uart_xmtr.sv
// UART transmitter: buffers bytes in a FIFO and sends 8N1/8N2 frames LSB first.
// Defining UART_XMTR_PARITY_EN inserts an even-parity bit between data and stop.
module uart_xmtr
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       serial_out,
   output logic       busy,
   output logic       tx_done,
   output logic [2:0] state_o
);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_xmtr: CLKS_PER_BIT must be >= 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_xmtr: STOP_BITS must be 1 or 2");
   end

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   uart_xmtr_state_t state_q, state_d;
   logic [BW-1:0]    baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             sout_q, sout_d;
   logic             busy_q, busy_d;
`ifdef UART_XMTR_PARITY_EN
   logic             par_q, par_d;
`endif

   logic       fifo_full, fifo_empty;
   logic [7:0] fifo_dout;
   logic       push, pop, baud_last;

   // A byte transfers on an edge where char_valid && char_ready; the source
   // holds char_in/char_valid while char_ready is low.
   assign char_ready = !fifo_full;
   assign push       = char_valid && char_ready;
   assign baud_last  = (baud_q == BAUD_LAST);

   assign serial_out = sout_q;
   assign busy       = busy_q;
   assign state_o    = state_q;
   assign tx_done    = (state_q == STOP) && baud_last && (bit_q == STOP_LAST);

   uart_xmtr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (char_in),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      baud_d  = baud_last ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      sout_d  = sout_q;
      pop     = 1'b0;
`ifdef UART_XMTR_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            baud_d = '0;
            pop    = !fifo_empty;
         end
         START: begin
            if (baud_last) begin
               sout_d  = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_last) begin
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
`ifdef UART_XMTR_PARITY_EN
                  sout_d  = par_q;
                  state_d = PARITY;
`else
                  sout_d  = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  sout_d  = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_XMTR_PARITY_EN
         PARITY: begin
            if (baud_last) begin
               sout_d  = 1'b1;
               bit_d   = '0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (baud_last) begin
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = IDLE;
                  pop     = !fifo_empty;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            sout_d  = 1'b1;
         end
      endcase

      // Frame start, whether from IDLE or chained straight off a stop bit.
      if (pop) begin
         shift_d = fifo_dout;
         sout_d  = 1'b0;
         baud_d  = '0;
         bit_d   = '0;
         state_d = START;
`ifdef UART_XMTR_PARITY_EN
         par_d   = even_parity(fifo_dout);
`endif
      end

      // No pop happens when the next state is IDLE, so the FIFO is non-empty
      // next cycle exactly when it is now or a byte is being pushed.
      busy_d = (state_d != IDLE) || !fifo_empty || push;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         sout_q  <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_XMTR_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         sout_q  <= sout_d;
         busy_q  <= busy_d;
`ifdef UART_XMTR_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_xmtr.sv
// Self-checking bench for uart_xmtr: exact-timing frame checks, handshake and
// FIFO back-pressure, reset abort, and a line decoder fed by a byte scoreboard.
module tb_uart_xmtr;
   import uart_pkg::*;

   localparam int CPB = 4;
`ifdef UART_XMTR_PARITY_EN
   localparam int STOP_BITS = 2;
   localparam int PAR_BITS  = 1;
`else
   localparam int STOP_BITS = 1;
   localparam int PAR_BITS  = 0;
`endif
   localparam int FRAME_BITS = 1 + 8 + PAR_BITS + STOP_BITS;
   localparam int FRAME      = FRAME_BITS * CPB;
   localparam int TMO        = 5000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] char_in = 8'h00;
   logic       char_valid = 1'b0;
   logic       char_ready, serial_out, busy, tx_done;
   logic [2:0] state_o;

   uart_xmtr #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .serial_out (serial_out),
      .busy       (busy),
      .tx_done    (tx_done),
      .state_o    (state_o)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int         checks = 0;
   int         fails  = 0;
   logic [7:0] exp_q[$];
   int         done_q[$];
   bit         rx_en = 1'b0;
   int         rx_count = 0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Line level of bit slot idx of the frame that carries byte b.
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (PAR_BITS == 1 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   always @(negedge clock) if (tx_done === 1'b1) done_q.push_back(cyc);

   // ---------------- scoreboard: mid-bit line decoder ----------------
   logic [7:0] rx_byte;
   logic [7:0] rx_exp;
   always begin
      @(negedge clock);
      if (rx_en && serial_out === 1'b0) begin
         repeat (CPB/2) @(negedge clock);
         checks++;
         if (serial_out !== 1'b0) begin
            fails++;
            $display("FAIL rx_start_bit: line=%b required 0 (cycle %0d)", serial_out, cyc);
         end
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            rx_byte[i] = serial_out;
         end
`ifdef UART_XMTR_PARITY_EN
         repeat (CPB) @(negedge clock);
         checks++;
         if (serial_out !== ^rx_byte) begin
            fails++;
            $display("FAIL rx_parity: line=%b required %b (cycle %0d)", serial_out, ^rx_byte, cyc);
         end
`endif
         for (int s = 0; s < STOP_BITS; s++) begin
            repeat (CPB) @(negedge clock);
            checks++;
            if (serial_out !== 1'b1) begin
               fails++;
               $display("FAIL rx_stop_bit: line=%b required 1 (cycle %0d)", serial_out, cyc);
            end
         end
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rx_unexpected_frame: got %h, required no frame", rx_byte);
         end else begin
            rx_exp = exp_q.pop_front();
            if (rx_byte !== rx_exp) begin
               fails++;
               $display("FAIL rx_data: got %h required %h", rx_byte, rx_exp);
            end
         end
         rx_count++;
      end
   end

   // ---------------- driver tasks (entered on a negedge) ----------------
   task automatic push_byte(input logic [7:0] b, output int edge_n);
      int n = 0;
      char_in    = b;
      char_valid = 1'b1;
      while (char_ready !== 1'b1 && n < TMO) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n >= TMO) begin
         fails++;
         $display("FAIL push_timeout: char_ready=%b required 1", char_ready);
      end
      @(posedge clock);
      #1 edge_n = cyc;
      exp_q.push_back(b);
      @(negedge clock);
      char_valid = 1'b0;
      char_in    = 8'($urandom);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(busy === 1'b0 && serial_out === 1'b1) && n < TMO) begin
         @(negedge clock);
         n++;
      end
      repeat (2*CPB) @(negedge clock);
      checks++;
      if (n >= TMO) begin
         fails++;
         $display("FAIL %s_drain: busy=%b required 0 within %0d cycles", name, busy, TMO);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      char_valid = 1'b0;
      repeat (3) @(negedge clock);
      checks += 5;
      if (serial_out !== 1'b1) begin fails++; $display("FAIL reset_serial_out: %b required 1", serial_out); end
      if (tx_done !== 1'b0)    begin fails++; $display("FAIL reset_tx_done: %b required 0", tx_done); end
      if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: %b required 0", busy); end
      if (char_ready !== 1'b1) begin fails++; $display("FAIL reset_char_ready: %b required 1", char_ready); end
      if (state_o !== 3'(IDLE)) begin fails++; $display("FAIL reset_state: %0d required %0d", state_o, IDLE); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_single(input logic [7:0] b);
      int   n;
      logic exp_line;
      push_byte(b, n);
      checks++;
      if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_push: %b required 1", busy); end
      for (int k = 1; k <= FRAME + 1; k++) begin
         @(negedge clock);
         exp_line = (k <= FRAME) ? frame_bit(b, (k - 1) / CPB) : 1'b1;
         checks += 3;
         if (serial_out !== exp_line) begin
            fails++;
            $display("FAIL single_line byte %h N+%0d: %b required %b", b, k, serial_out, exp_line);
         end
         if (tx_done !== (k == FRAME)) begin
            fails++;
            $display("FAIL single_tx_done byte %h N+%0d: %b required %b", b, k, tx_done, (k == FRAME));
         end
         if (busy !== (k <= FRAME)) begin
            fails++;
            $display("FAIL single_busy byte %h N+%0d: %b required %b", b, k, busy, (k <= FRAME));
         end
      end
      wait_idle("single");
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [6];
      int accepted = 0;
      int drop_at  = -1;
      int n = 0;
      for (int i = 0; i < 6; i++) seq[i] = 8'(8'h41 + i);
      done_q.delete();
      char_valid = 1'b1;
      char_in    = seq[0];
      while (accepted < 6 && n < TMO) begin
         if (char_ready === 1'b1) begin
            @(posedge clock);
            exp_q.push_back(seq[accepted]);
            accepted++;
            @(negedge clock);
            if (accepted < 6) char_in = seq[accepted];
         end else begin
            if (drop_at < 0) drop_at = accepted;
            @(negedge clock);
         end
         n++;
      end
      char_valid = 1'b0;
      checks += 2;
      if (accepted !== 6) begin fails++; $display("FAIL b2b_accepted: %0d required 6", accepted); end
      if (drop_at !== 5)  begin fails++; $display("FAIL b2b_ready_drop: after %0d bytes required 5", drop_at); end
      wait_idle("b2b");
      checks++;
      if (done_q.size() !== 6) begin
         fails++;
         $display("FAIL b2b_tx_done_count: %0d required 6", done_q.size());
      end
      for (int i = 1; i < done_q.size(); i++) begin
         checks++;
         if (done_q[i] - done_q[i-1] !== FRAME) begin
            fails++;
            $display("FAIL b2b_tx_done_spacing %0d: %0d required %0d", i, done_q[i] - done_q[i-1], FRAME);
         end
      end
   endtask

   task automatic test_simul_push_pop();
      int n, k;
      for (int i = 0; i < 4; i++) push_byte(8'($urandom), n);
      done_q.delete();
      k = 0;
      while (tx_done !== 1'b1 && k < TMO) begin
         @(negedge clock);
         k++;
      end
      checks++;
      if (k >= TMO) begin fails++; $display("FAIL simul_wait_tx_done: not seen, required within %0d", TMO); end
      char_in    = 8'($urandom);
      char_valid = 1'b1;
      checks++;
      if (char_ready !== 1'b1) begin fails++; $display("FAIL simul_ready_before: %b required 1", char_ready); end
      @(posedge clock);
      exp_q.push_back(char_in);
      @(negedge clock);
      char_valid = 1'b0;
      checks++;
      if (char_ready !== 1'b1) begin fails++; $display("FAIL simul_ready_after: %b required 1", char_ready); end
      push_byte(8'($urandom), n);
      checks++;
      if (char_ready !== 1'b0) begin fails++; $display("FAIL simul_full_after_extra: %b required 0", char_ready); end
      wait_idle("simul");
   endtask

   task automatic test_reset_mid_frame();
      int n0, n, low_cnt;
      rx_en = 1'b0;
      push_byte(8'hA5, n0);
      push_byte(8'($urandom), n);
      push_byte(8'($urandom), n);
      n = 0;
      while (cyc < n0 + 1 + CPB * 4 + 1 && n < TMO) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (serial_out !== frame_bit(8'hA5, 4)) begin
         fails++;
         $display("FAIL rst_mid_bit3: %b required %b", serial_out, frame_bit(8'hA5, 4));
      end
      done_q.delete();
      reset = 1'b1;
      @(negedge clock);
      checks += 4;
      if (serial_out !== 1'b1) begin fails++; $display("FAIL rst_mid_serial_out: %b required 1", serial_out); end
      if (busy !== 1'b0)       begin fails++; $display("FAIL rst_mid_busy: %b required 0", busy); end
      if (char_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_char_ready: %b required 1", char_ready); end
      if (tx_done !== 1'b0)    begin fails++; $display("FAIL rst_mid_tx_done: %b required 0", tx_done); end
      reset = 1'b0;
      low_cnt = 0;
      repeat (3 * FRAME) begin
         @(negedge clock);
         if (serial_out !== 1'b1) low_cnt++;
      end
      checks += 2;
      if (low_cnt !== 0)       begin fails++; $display("FAIL rst_mid_no_frames: %0d non-idle cycles required 0", low_cnt); end
      if (done_q.size() !== 0) begin fails++; $display("FAIL rst_mid_no_tx_done: %0d pulses required 0", done_q.size()); end
      exp_q.delete();
      rx_en = 1'b1;
   endtask

   task automatic test_random();
      int n, cnt, rx0, gap;
      cnt = $urandom_range(12, 20);
      rx0 = rx_count;
      for (int i = 0; i < cnt; i++) begin
         gap = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 60);
         repeat (gap) @(negedge clock);
         push_byte(8'($urandom), n);
      end
      wait_idle("random");
      checks++;
      if (rx_count - rx0 !== cnt) begin
         fails++;
         $display("FAIL random_frame_count: %0d required %0d", rx_count - rx0, cnt);
      end
   endtask

   task automatic test_loopback();
      int n, rx0;
      rx0 = rx_count;
      for (int c = 8'h41; c <= 8'h5A; c++) push_byte(8'(c), n);
      wait_idle("loopback");
      checks++;
      if (rx_count - rx0 !== 26) begin
         fails++;
         $display("FAIL loopback_frame_count: %0d required 26", rx_count - rx0);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      rx_en = 1'b1;
      test_single(8'h55);
      test_single(8'h07);
      test_single(8'($urandom));
      test_back_to_back();
      test_simul_push_pop();
      test_reset_mid_frame();
      test_random();
      test_loopback();
      checks++;
      if (exp_q.size() !== 0) begin
         fails++;
         $display("FAIL leftover_expected: %0d bytes never seen, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/uart_xmtr.md
Name: uart_xmtr

Overview:
- Serial UART transmitter; the transmit-direction counterpart of uart_rcvr.
- Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as 8N1 (8N2 optional) frames on serial_out, LSB first.
- Used in the testbench to drive the DUT's uart_sin, and loopback-checked against uart_rcvr.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be >= 2; elaboration $error otherwise.
- STOP_BITS, 1: number of stop bits per frame, 1 or 2. Any other value is an elaboration $error.
- FIFO_DEPTH, 4: number of byte entries in the input FIFO. Power of 2, >= 2.

Ports:
- clock, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- char_in, input, 8: byte to transmit.
- char_valid, input, 1: char_in is valid this cycle.
- char_ready, output, 1: FIFO can accept a byte; combinational !fifo_full.
- serial_out, output, 1: UART line; idles high.
- busy, output, 1: registered; high when FSM != IDLE or FIFO non-empty.
- tx_done, output, 1: one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values: serial_out=1, tx_done=0, busy=0, FIFO empty, so char_ready=1. FSM=IDLE; baud counter, bit counter and shift register all 0.
- Reset mid-frame: on the next edge, serial_out=1, the frame is aborted (no tx_done) and the FIFO is flushed.
- Handshake:
  - A byte is pushed on an edge where char_valid && char_ready.
  - While char_ready=0, the source holds char_in/char_valid; nothing is pushed.
  - Push and pop in the same cycle are legal whenever not full; occupancy is then unchanged.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - If the FIFO is non-empty, pop into the shift register, drive serial_out=0 and go to START.
  - Latency: a byte pushed at edge N into an empty FIFO with the FSM idle gives the start bit on serial_out from edge N+1.
- Bit timing: every state holds its bit for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances.
- START -> DATA: emit bit 0 first; shift right each bit period. A 3-bit counter ends after bit 7.
- DATA -> STOP (or PARITY when enabled): serial_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of STOP:
  - Pulse tx_done for one cycle.
  - If the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
- FIFO: circular pointers one bit wider than log2(FIFO_DEPTH).
  - Full when the MSBs differ and the lower bits are equal.
  - Empty when the pointers are equal. Wrap-around is natural modulo arithmetic.
- char_in is sampled only at push; later changes do not affect queued data.

Optional Feature:
- Macro: UART_XMTR_PARITY_EN.
- Defined: a PARITY state follows DATA and emits the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles before STOP.
- Undefined: no PARITY state and no parity logic; frames are 8N1 / 8N2.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_xmtr_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam UART_DATA_BITS = 8;
  - function even_parity(logic [7:0]).
- Sub-module uart_xmtr_fifo: synchronous FIFO with push/pop/full/empty/dout, parameterised by FIFO_DEPTH.
- The FSM, baud counter and shifter stay in uart_xmtr.

Test Plan (all with CLKS_PER_BIT=4, STOP_BITS=1 unless noted):
- Single byte: push 0x55 at edge N.
  - serial_out=0 over cycles N+1..N+4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
  - tx_done pulses once at N+40; busy falls at N+41.
- Back-to-back: push 0x41,0x42,0x43,0x44,0x45,0x46 with char_valid held high.
  - char_ready drops after 5 accepted bytes (1 in the shifter, 4 queued).
  - 6 contiguous frames with no idle gap; 6 tx_done pulses, 40 cycles apart.
- Simultaneous push/pop: FIFO holding 3 bytes, push on the cycle STOP ends.
  - Occupancy stays 3; char_ready stays 1; byte order is preserved.
- Reset mid-frame: assert reset during bit 3 of 0xA5 with 2 bytes queued.
  - Next edge: serial_out=1, busy=0, char_ready=1, no tx_done; no further frames after reset releases.
- Loopback: uart_xmtr.serial_out feeds uart_rcvr.serial_in, with CLKS_PER_BIT matched to uart_rcvr's bit period. Send "A".."Z" (26 bytes).
  - uart_rcvr presents char_valid 26 times with bytes 0x41..0x5A in order.
- Parity: with UART_XMTR_PARITY_EN defined and STOP_BITS=2, send 0x07.
  - Frame is start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1,1.
  - Frame length 48 cycles.
